writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameters SHALL be: data_width, default 16, sample/register width; n_blocks, default 256, block index range.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  pipeline advance qualifier
- a_valid  in  1  channel A (misc branch) result valid
- a_ready  out  1  channel A accepted this cycle
- a_block  in  $clog2(n_blocks)  channel A block index
- a_dest  in  4  channel A destination register
- a_result  in  2*data_width  channel A result
- a_commit_id  in  9  channel A commit id
- a_commit_flag  in  1  channel A commit marker
- b_valid, b_ready, b_block, b_dest, b_result, b_commit_id, b_commit_flag: same directions, widths and meanings for channel B (MAC branch)
- wb_valid  out  1  writeback beat valid
- wb_ready  in  1  register file accepts beat
- wb_block  out  $clog2(n_blocks)  block index of beat
- wb_dest  out  4  destination register
- wb_data  out  data_width  write data
- wb_commit_id  out  9  commit id of beat
- wb_commit_flag  out  1  commit marker of beat
- commit_count  out  16  number of commit-flagged beats delivered
- last_grant  out  1  0 = A last granted, 1 = B last granted

Function
REQ-003 The block SHALL hold exactly one output register entry; slot_free = ~wb_valid | wb_ready.
REQ-004 Grant SHALL be computed combinationally: only A valid -> A; only B valid -> B; both valid -> channel opposite to last_grant; neither -> none.
REQ-005 a_ready SHALL equal enable & slot_free & grant_A; b_ready SHALL equal enable & slot_free & grant_B; never both high in one cycle.
REQ-006 On a rising edge with a transfer (x_valid & x_ready), the output register SHALL load the granted channel's block, dest, commit_id, commit_flag and wb_data = x_result[data_width-1:0], set wb_valid = 1, and update last_grant to the granted channel.
REQ-007 Latency SHALL be one cycle from accepted input to wb_valid; sustained throughput one beat per cycle when wb_ready is held high.
REQ-008 With wb_ready high and no transfer, wb_valid SHALL clear on the next edge; with wb_valid high and wb_ready low, all wb_* outputs SHALL hold unchanged.
REQ-009 Simultaneous wb_ready handshake and new transfer SHALL replace the entry in the same edge (wb_valid stays 1).
REQ-010 commit_count SHALL increment by 1 on each edge where wb_valid & wb_ready & wb_commit_flag, wrapping 0xFFFF -> 0x0000.
REQ-011 enable low SHALL freeze all state (entry, wb_valid, last_grant, commit_count) and force a_ready = b_ready = 0; wb_valid/wb_* remain driven, and a wb_ready handshake while enable is low SHALL NOT retire the entry or count.
REQ-012 last_grant SHALL change only on a transfer; a lone requester does not skip its priority turn logic beyond REQ-004.
REQ-013 Upper result bits SHALL be discarded without saturation (upstream stages saturate).

Reset
REQ-014 reset low SHALL asynchronously force wb_valid = 0, last_grant = 1 (A wins first tie), commit_count = 0; wb_block, wb_dest, wb_data, wb_commit_id, wb_commit_flag = 0.
REQ-015 Reset asserted mid-transfer SHALL discard the held entry; no beat SHALL be presented until a new transfer after reset release.

Verification
REQ-016 Bench SHALL cover:
- Reset release, A valid, a_result=0x0001_7FFF, a_dest=3, wb_ready=1 -> a_ready=1, next cycle wb_valid=1, wb_data=0x7FFF, wb_dest=3, last_grant=0.
- A and B valid every cycle, wb_ready=1 for 6 cycles -> grants A,B,A,B,A,B; one beat per cycle.
- wb_valid=1, wb_ready=0 for 4 cycles with both channels valid -> a_ready=b_ready=0, wb_* stable; wb_ready=1 -> entry retires and next grant loads same edge.
- Four commit-flagged beats and two unflagged delivered -> commit_count=4; preload toward 0xFFFF with 2 flagged beats -> wraps to 0x0001.
- enable=0 with wb_valid=1, wb_ready=1 -> entry retained, count unchanged, readies 0; enable=1 -> retires.
- reset pulsed low while wb_valid=1 -> wb_valid=0 immediately, commit_count=0, first tie after release grants A.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Two-channel writeback arbiter: alternates between the misc (A) and MAC (B) result
// channels on ties and holds one output entry toward the register file.
module writeback_arbiter #(
  parameter int data_width = 16,
  parameter int n_blocks   = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,

  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [$clog2(n_blocks)-1:0]   a_block,
  input  logic [3:0]                    a_dest,
  input  logic [2*data_width-1:0]       a_result,
  input  logic [8:0]                    a_commit_id,
  input  logic                          a_commit_flag,

  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [$clog2(n_blocks)-1:0]   b_block,
  input  logic [3:0]                    b_dest,
  input  logic [2*data_width-1:0]       b_result,
  input  logic [8:0]                    b_commit_id,
  input  logic                          b_commit_flag,

  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [$clog2(n_blocks)-1:0]   wb_block,
  output logic [3:0]                    wb_dest,
  output logic [data_width-1:0]         wb_data,
  output logic [8:0]                    wb_commit_id,
  output logic                          wb_commit_flag,
  output logic [15:0]                   commit_count,
  output logic                          last_grant
);

  localparam int block_width = $clog2(n_blocks);

  logic                   wb_valid_reg;
  logic [block_width-1:0] wb_block_reg;
  logic [3:0]             wb_dest_reg;
  logic [data_width-1:0]  wb_data_reg;
  logic [8:0]             wb_commit_id_reg;
  logic                   wb_commit_flag_reg;
  logic [15:0]            commit_count_reg;
  logic                   last_grant_reg;

  logic                   slot_free;
  logic                   grant_a;
  logic                   grant_b;
  logic                   take_a;
  logic                   take_b;
  logic                   load;
  logic                   retire;

  logic [block_width-1:0] sel_block;
  logic [3:0]             sel_dest;
  logic [data_width-1:0]  sel_data;
  logic [8:0]             sel_commit_id;
  logic                   sel_commit_flag;

  // Upstream stages saturate, so the upper half of each result is dropped here.
  logic unused_result_hi;
  assign unused_result_hi = ^{a_result[2*data_width-1:data_width],
                              b_result[2*data_width-1:data_width]};

  assign slot_free = ~wb_valid_reg | wb_ready;

  // On a tie the channel that did not win last time goes first.
  assign grant_a = a_valid & (~b_valid | last_grant_reg);
  assign grant_b = b_valid & (~a_valid | ~last_grant_reg);

  assign a_ready = enable & slot_free & grant_a;
  assign b_ready = enable & slot_free & grant_b;

  assign take_a = a_valid & a_ready;
  assign take_b = b_valid & b_ready;
  assign load   = take_a | take_b;
  assign retire = enable & wb_valid_reg & wb_ready;

  always_comb begin
    sel_block       = a_block;
    sel_dest        = a_dest;
    sel_data        = a_result[data_width-1:0];
    sel_commit_id   = a_commit_id;
    sel_commit_flag = a_commit_flag;
    if (take_b) begin
      sel_block       = b_block;
      sel_dest        = b_dest;
      sel_data        = b_result[data_width-1:0];
      sel_commit_id   = b_commit_id;
      sel_commit_flag = b_commit_flag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_reg       <= 1'b0;
      wb_block_reg       <= '0;
      wb_dest_reg        <= '0;
      wb_data_reg        <= '0;
      wb_commit_id_reg   <= '0;
      wb_commit_flag_reg <= 1'b0;
      commit_count_reg   <= '0;
      last_grant_reg     <= 1'b1;
    end else if (enable) begin
      if (load) begin
        wb_valid_reg       <= 1'b1;
        wb_block_reg       <= sel_block;
        wb_dest_reg        <= sel_dest;
        wb_data_reg        <= sel_data;
        wb_commit_id_reg   <= sel_commit_id;
        wb_commit_flag_reg <= sel_commit_flag;
        last_grant_reg     <= take_b;
      end else if (wb_ready) begin
        wb_valid_reg <= 1'b0;
      end
      if (retire && wb_commit_flag_reg) begin
        commit_count_reg <= commit_count_reg + 16'd1;
      end
    end
  end

  assign wb_valid       = wb_valid_reg;
  assign wb_block       = wb_block_reg;
  assign wb_dest        = wb_dest_reg;
  assign wb_data        = wb_data_reg;
  assign wb_commit_id   = wb_commit_id_reg;
  assign wb_commit_flag = wb_commit_flag_reg;
  assign commit_count   = commit_count_reg;
  assign last_grant     = last_grant_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: grant alternation, stalls, commit counting,
// enable freeze and asynchronous reset.
module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        a_valid, a_ready, a_commit_flag;
  logic [7:0]  a_block;
  logic [3:0]  a_dest;
  logic [31:0] a_result;
  logic [8:0]  a_commit_id;
  logic        b_valid, b_ready, b_commit_flag;
  logic [7:0]  b_block;
  logic [3:0]  b_dest;
  logic [31:0] b_result;
  logic [8:0]  b_commit_id;
  logic        wb_valid, wb_ready, wb_commit_flag;
  logic [7:0]  wb_block;
  logic [3:0]  wb_dest;
  logic [15:0] wb_data;
  logic [8:0]  wb_commit_id;
  logic [15:0] commit_count;
  logic        last_grant;

  int checks;
  int errors;

  writeback_arbiter #(.data_width(16), .n_blocks(256)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .a_valid(a_valid), .a_ready(a_ready), .a_block(a_block), .a_dest(a_dest),
    .a_result(a_result), .a_commit_id(a_commit_id), .a_commit_flag(a_commit_flag),
    .b_valid(b_valid), .b_ready(b_ready), .b_block(b_block), .b_dest(b_dest),
    .b_result(b_result), .b_commit_id(b_commit_id), .b_commit_flag(b_commit_flag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_block(wb_block), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_commit_id(wb_commit_id), .wb_commit_flag(wb_commit_flag),
    .commit_count(commit_count), .last_grant(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; enable = 1'b1; wb_ready = 1'b0;
    a_valid = 0; a_block = 0; a_dest = 0; a_result = 0; a_commit_id = 0; a_commit_flag = 0;
    b_valid = 0; b_block = 0; b_dest = 0; b_result = 0; b_commit_id = 0; b_commit_flag = 0;
    tick(); tick();

    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd1);
    check("rst_count", 32'(commit_count), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_dest", 32'(wb_dest), 32'd0);

    reset = 1'b1;
    tick();

    // Single A beat; upper result half is dropped.
    a_valid = 1; a_result = 32'h0001_7FFF; a_dest = 4'd3; a_block = 8'd5; a_commit_id = 9'h1A5;
    wb_ready = 1;
    settle();
    check("t1_a_ready", 32'(a_ready), 32'd1);
    check("t1_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_data", 32'(wb_data), 32'h7FFF);
    check("t1_wb_dest", 32'(wb_dest), 32'd3);
    check("t1_wb_block", 32'(wb_block), 32'd5);
    check("t1_wb_commit_id", 32'(wb_commit_id), 32'h1A5);
    check("t1_last_grant", 32'(last_grant), 32'd0);
    a_valid = 0;
    tick();
    check("t1_retired", 32'(wb_valid), 32'd0);

    // Lone B beat: B wins and last_grant moves to B.
    b_valid = 1; b_result = 32'h1234_B222; b_dest = 4'd9; b_block = 8'd200; b_commit_id = 9'h0F0;
    settle();
    check("tb_b_ready", 32'(b_ready), 32'd1);
    tick();
    check("tb_wb_data", 32'(wb_data), 32'hB222);
    check("tb_wb_block", 32'(wb_block), 32'd200);
    check("tb_last_grant", 32'(last_grant), 32'd1);

    // Both channels valid every cycle: strict alternation starting with A.
    a_valid = 1; a_result = 32'hFFFF_A111; a_dest = 4'd1;
    for (int i = 0; i < 6; i++) begin
      settle();
      check($sformatf("alt%0d_a_ready", i), 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("alt%0d_b_ready", i), 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check($sformatf("alt%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("alt%0d_wb_data", i), 32'(wb_data), (i % 2 == 0) ? 32'hA111 : 32'hB222);
    end

    // Register file stalls: nothing accepted, entry held.
    wb_ready = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("stall%0d_a_ready", i), 32'(a_ready), 32'd0);
      check($sformatf("stall%0d_b_ready", i), 32'(b_ready), 32'd0);
      tick();
      check($sformatf("stall%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("stall%0d_wb_data", i), 32'(wb_data), 32'hB222);
      check($sformatf("stall%0d_wb_dest", i), 32'(wb_dest), 32'd9);
    end
    wb_ready = 1;
    settle();
    check("unstall_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("unstall_wb_valid", 32'(wb_valid), 32'd1);
    check("unstall_wb_data", 32'(wb_data), 32'hA111);
    check("unstall_last_grant", 32'(last_grant), 32'd0);
    a_valid = 0; b_valid = 0;
    tick();
    check("unstall_drain", 32'(wb_valid), 32'd0);
    check("count_zero", 32'(commit_count), 32'd0);

    // Commit counting: flags 1,0,1,1,0,1 -> four counted beats.
    a_valid = 1;
    for (int i = 0; i < 6; i++) begin
      a_commit_flag = (i == 1 || i == 4) ? 1'b0 : 1'b1;
      a_result = 32'(16'hC000 + i);
      tick();
      check($sformatf("cnt%0d_wb_data", i), 32'(wb_data), 32'(16'hC000 + i));
    end
    a_valid = 0;
    tick();
    check("cnt_total", 32'(commit_count), 32'd4);

    // Run the counter up to 0xFFFF, then two more flagged beats wrap it to 1.
    a_valid = 1; a_commit_flag = 1;
    for (int i = 0; i < 65531; i++) @(posedge clk);
    #1;
    a_valid = 0;
    tick();
    check("cnt_ffff", 32'(commit_count), 32'hFFFF);
    a_valid = 1;
    tick(); tick();
    a_valid = 0;
    tick();
    check("cnt_wrap", 32'(commit_count), 32'h0001);

    // Enable low freezes the held entry even with wb_ready high.
    wb_ready = 0; a_valid = 1; a_commit_flag = 1; a_result = 32'h0000_5A5A;
    tick();
    check("en_loaded", 32'(wb_data), 32'h5A5A);
    b_valid = 1; enable = 0; wb_ready = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("en%0d_a_ready", i), 32'(a_ready), 32'd0);
      check($sformatf("en%0d_b_ready", i), 32'(b_ready), 32'd0);
      tick();
      check($sformatf("en%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("en%0d_wb_data", i), 32'(wb_data), 32'h5A5A);
      check($sformatf("en%0d_count", i), 32'(commit_count), 32'd1);
      check($sformatf("en%0d_last_grant", i), 32'(last_grant), 32'd0);
    end
    a_valid = 0; b_valid = 0; enable = 1;
    tick();
    check("en_retired", 32'(wb_valid), 32'd0);
    check("en_count", 32'(commit_count), 32'd2);

    // Asynchronous reset while an A beat is held.
    wb_ready = 0; a_valid = 1; a_commit_flag = 0; a_result = 32'h0000_1357;
    tick();
    check("rst2_loaded", 32'(wb_valid), 32'd1);
    check("rst2_pre_grant", 32'(last_grant), 32'd0);
    #2;
    reset = 0;
    #1;
    check("rst2_wb_valid", 32'(wb_valid), 32'd0);
    check("rst2_count", 32'(commit_count), 32'd0);
    check("rst2_last_grant", 32'(last_grant), 32'd1);
    check("rst2_wb_data", 32'(wb_data), 32'd0);
    tick();
    check("rst2_held", 32'(wb_valid), 32'd0);
    reset = 1;
    b_valid = 1; wb_ready = 1;
    settle();
    check("rst2_tie_a_ready", 32'(a_ready), 32'd1);
    check("rst2_tie_b_ready", 32'(b_ready), 32'd0);
    tick();
    check("rst2_tie_wb_data", 32'(wb_data), 32'h1357);
    check("rst2_tie_last_grant", 32'(last_grant), 32'd0);
    a_valid = 0; b_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
